// File: rtl/gsa_pkg.sv
// rtl/gsa_pkg.sv - shared state encoding, width helper and default layout for group_sum_argmax
package gsa_pkg;

   // Network output layout: 10 classes of 5 bits each
   localparam int DEF_NUM_CLASSES = 10;
   localparam int DEF_GROUP_BITS  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so derived widths stay legal for tiny configs
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/popcount.sv
// rtl/popcount.sv - combinational set-bit counter for one class group
module popcount
   import gsa_pkg::*;
#(
   parameter  int W  = 5,
   localparam int CW = clog2(W + 1)
) (
   input  logic [W-1:0]  i_bits,
   output logic [CW-1:0] o_count
);

   // Ripple sum of the input bits; W is small so a plain adder chain is fine
   always_comb begin
      o_count = '0;
      for (int i = 0; i < W; i++) begin
         o_count = o_count + CW'(i_bits[i]);
      end
   end

endmodule

// File: rtl/group_sum_argmax.sv
// rtl/group_sum_argmax.sv - sequential per-class popcount and argmax; optional GSA_SCORES_EN exposes all scores
module group_sum_argmax
   import gsa_pkg::*;
#(
   parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter  int GROUP_BITS  = DEF_GROUP_BITS,
   localparam int CLS_W       = clog2(NUM_CLASSES),
   localparam int CNT_W       = clog2(GROUP_BITS + 1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start,
   input  logic [NUM_CLASSES*GROUP_BITS-1:0] i_bits,
   output logic                              o_busy,
   output logic                              o_valid,
   output logic [CLS_W-1:0]                  o_class,
   output logic [CNT_W-1:0]                  o_score
`ifdef GSA_SCORES_EN
   ,
   output logic [NUM_CLASSES*CNT_W-1:0]      o_scores
`endif
);

   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

   state_t                            state_q, state_d;
   logic [NUM_CLASSES*GROUP_BITS-1:0] capture_q, capture_d;
   logic [CLS_W-1:0]                  idx_q, idx_d;
   logic [CLS_W-1:0]                  best_cls_q, best_cls_d;
   logic [CNT_W-1:0]                  best_score_q, best_score_d;
   logic                              busy_q, busy_d;
   logic                              valid_q, valid_d;
   logic [CLS_W-1:0]                  class_q, class_d;
   logic [CNT_W-1:0]                  score_q, score_d;
`ifdef GSA_SCORES_EN
   logic [NUM_CLASSES*CNT_W-1:0]      scores_q, scores_d;
`endif

   logic [GROUP_BITS-1:0] group_a [NUM_CLASSES];
   logic [CNT_W-1:0]      cnt;

   // Split the captured vector into addressable class groups
   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_groups
      assign group_a[k] = capture_q[k*GROUP_BITS +: GROUP_BITS];
   end

   popcount #(.W(GROUP_BITS)) u_popcount (
      .i_bits  (group_a[idx_q]),
      .o_count (cnt)
   );

   // Next-state logic: accept in IDLE, scan one group per cycle, pulse result in DONE
   always_comb begin
      state_d      = state_q;
      capture_d    = capture_q;
      idx_d        = idx_q;
      best_cls_d   = best_cls_q;
      best_score_d = best_score_q;
      busy_d       = busy_q;
      valid_d      = 1'b0;
      class_d      = class_q;
      score_d      = score_q;
`ifdef GSA_SCORES_EN
      scores_d     = scores_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               capture_d = i_bits;
               idx_d     = '0;
               busy_d    = 1'b1;
               state_d   = ST_SCAN;
`ifdef GSA_SCORES_EN
               scores_d  = '0;
`endif
            end
         end
         ST_SCAN: begin
            // Strict greater-than keeps the lowest index on ties
            if ((idx_q == '0) || (cnt > best_score_q)) begin
               best_cls_d   = idx_q;
               best_score_d = cnt;
            end
`ifdef GSA_SCORES_EN
            for (int k = 0; k < NUM_CLASSES; k++) begin
               if (idx_q == CLS_W'(k)) begin
                  scores_d[k*CNT_W +: CNT_W] = cnt;
               end
            end
`endif
            if (idx_q == LAST_IDX) begin
               // Publish the winner including this final group's comparison
               class_d = best_cls_d;
               score_d = best_score_d;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any scan in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         capture_q    <= '0;
         idx_q        <= '0;
         best_cls_q   <= '0;
         best_score_q <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         class_q      <= '0;
         score_q      <= '0;
`ifdef GSA_SCORES_EN
         scores_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         capture_q    <= capture_d;
         idx_q        <= idx_d;
         best_cls_q   <= best_cls_d;
         best_score_q <= best_score_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         class_q      <= class_d;
         score_q      <= score_d;
`ifdef GSA_SCORES_EN
         scores_q     <= scores_d;
`endif
      end
   end

   assign o_busy  = busy_q;
   assign o_valid = valid_q;
   assign o_class = class_q;
   assign o_score = score_q;
`ifdef GSA_SCORES_EN
   assign o_scores = scores_q;
`endif

endmodule
